// File: rtl/pr_elastic_stage.sv
// Flow-controlled pipeline register with a 2-entry skid buffer, synchronous flush
// and bubble masking of control/address fields.
module pr_elastic_stage #(
  parameter int DATA_WIDTH = 128,
  parameter int CTRL_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [1:0]            occupancy
);

  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic [CTRL_WIDTH-1:0] m_ctrl;
  logic [ADDR_WIDTH-1:0] m_addr;

  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic [CTRL_WIDTH-1:0] s_ctrl;
  logic [ADDR_WIDTH-1:0] s_addr;

  logic in_fire;
  logic m_take;

  // Ready depends only on the skid flag, so there is no path from out_ready.
  assign in_ready = ~s_valid;
  assign in_fire  = in_valid & ~s_valid;
  assign m_take   = ~m_valid | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ctrl  <= '0;
      m_addr  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      m_ctrl  <= '0;
      m_addr  <= '0;
    end else if (m_take) begin
      if (s_valid) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
        m_ctrl  <= s_ctrl;
        m_addr  <= s_addr;
      end else if (in_fire) begin
        m_valid <= 1'b1;
        m_data  <= in_data;
        m_ctrl  <= in_ctrl;
        m_addr  <= in_addr;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  // The skid only fills while M is stalled; any M advance drains it first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid <= 1'b0;
      s_data  <= '0;
      s_ctrl  <= '0;
      s_addr  <= '0;
    end else if (flush) begin
      s_valid <= 1'b0;
      s_ctrl  <= '0;
      s_addr  <= '0;
    end else if (m_take) begin
      s_valid <= 1'b0;
    end else if (in_fire) begin
      s_valid <= 1'b1;
      s_data  <= in_data;
      s_ctrl  <= in_ctrl;
      s_addr  <= in_addr;
    end
  end

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_ctrl & {CTRL_WIDTH{m_valid}};
  assign out_addr  = m_addr & {ADDR_WIDTH{m_valid}};
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_pr_elastic_stage.sv
// Directed and scoreboarded random checks of pr_elastic_stage.
module tb_pr_elastic_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [7:0]   in_ctrl = '0;
  logic [4:0]   in_addr = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [7:0]   out_ctrl;
  logic [4:0]   out_addr;
  logic [1:0]   occupancy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [127:0] data;
    logic [7:0]   ctrl;
    logic [4:0]   addr;
  } entry_t;

  entry_t sb[$];

  pr_elastic_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_addr(out_addr),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [127:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = d[7:0];
    in_addr   = d[4:0];
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic v, input logic [127:0] d,
                            input logic [1:0] occ, input logic rdy);
    checkOutput({tag, ".valid"}, {127'b0, out_valid}, {127'b0, v});
    if (v) checkOutput({tag, ".data"}, out_data, d);
    checkOutput({tag, ".ctrl"}, {120'b0, out_ctrl}, v ? {120'b0, d[7:0]} : 128'b0);
    checkOutput({tag, ".addr"}, {123'b0, out_addr}, v ? {123'b0, d[4:0]} : 128'b0);
    checkOutput({tag, ".occ"}, {126'b0, occupancy}, {126'b0, occ});
    checkOutput({tag, ".rdy"}, {127'b0, in_ready}, {127'b0, rdy});
  endtask

  initial begin
    entry_t       offer;
    entry_t       head;
    logic         pending;
    logic         rdy_before;
    logic         fire_in;
    logic         fire_out;

    // Reset held, then released
    #1;
    checkState("reset_held", 1'b0, 128'h0, 2'd0, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    checkState("reset_release", 1'b0, 128'h0, 2'd0, 1'b1);

    // Streaming pass-through
    applyStimulus(1'b1, 128'h11, 1'b1, 1'b0); tick();
    checkState("stream_11", 1'b1, 128'h11, 2'd1, 1'b1);
    applyStimulus(1'b1, 128'h22, 1'b1, 1'b0); tick();
    checkState("stream_22", 1'b1, 128'h22, 2'd1, 1'b1);
    applyStimulus(1'b1, 128'h33, 1'b1, 1'b0); tick();
    checkState("stream_33", 1'b1, 128'h33, 2'd1, 1'b1);
    applyStimulus(1'b0, 128'h0, 1'b1, 1'b0); tick();
    checkState("stream_drain", 1'b0, 128'h0, 2'd0, 1'b1);

    // Backpressure fills the skid, C must wait
    applyStimulus(1'b1, 128'hAA, 1'b0, 1'b0); tick();
    checkState("bp_A", 1'b1, 128'hAA, 2'd1, 1'b1);
    applyStimulus(1'b1, 128'hBB, 1'b0, 1'b0); tick();
    checkState("bp_AB", 1'b1, 128'hAA, 2'd2, 1'b0);
    applyStimulus(1'b1, 128'hCC, 1'b0, 1'b0); tick();
    checkState("bp_C_blocked", 1'b1, 128'hAA, 2'd2, 1'b0);
    applyStimulus(1'b1, 128'hCC, 1'b1, 1'b0); tick();
    checkState("bp_out_B", 1'b1, 128'hBB, 2'd1, 1'b1);
    applyStimulus(1'b1, 128'hCC, 1'b1, 1'b0); tick();
    checkState("bp_out_C", 1'b1, 128'hCC, 2'd1, 1'b1);
    applyStimulus(1'b0, 128'h0, 1'b1, 1'b0); tick();
    checkState("bp_drain", 1'b0, 128'h0, 2'd0, 1'b1);

    // Flush of a full stage with all-ones control
    applyStimulus(1'b1, 128'h1FF, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 128'h2FF, 1'b0, 1'b0); tick();
    checkState("flush_full", 1'b1, 128'h1FF, 2'd2, 1'b0);
    applyStimulus(1'b0, 128'h0, 1'b0, 1'b1); tick();
    checkState("flush_done", 1'b0, 128'h0, 2'd0, 1'b1);

    // Input offered during flush is discarded
    applyStimulus(1'b1, 128'hDD, 1'b1, 1'b1); tick();
    checkState("flush_discard", 1'b0, 128'h0, 2'd0, 1'b1);
    applyStimulus(1'b0, 128'h0, 1'b1, 1'b0); tick();
    checkState("flush_after", 1'b0, 128'h0, 2'd0, 1'b1);

    // Asynchronous reset between edges while full
    applyStimulus(1'b1, 128'h5A, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 128'h6B, 1'b0, 1'b0); tick();
    checkState("async_full", 1'b1, 128'h5A, 2'd2, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkState("async_reset", 1'b0, 128'h0, 2'd0, 1'b1);
    applyStimulus(1'b0, 128'h0, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    checkState("async_release1", 1'b0, 128'h0, 2'd0, 1'b1);
    tick();
    checkState("async_release2", 1'b0, 128'h0, 2'd0, 1'b1);

    // Random handshake against a scoreboard
    pending = 1'b0;
    offer   = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!pending) begin
        offer.data = {$urandom, $urandom, $urandom, $urandom};
        offer.ctrl = 8'($urandom);
        offer.addr = 5'($urandom);
        in_valid   = ($urandom_range(0, 3) != 0);
      end
      in_data   = offer.data;
      in_ctrl   = offer.ctrl;
      in_addr   = offer.addr;
      flush     = 1'b0;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      rdy_before = in_ready;
      out_ready  = ~out_ready;
      #1;
      checkOutput("rnd_ready_comb", {127'b0, in_ready}, {127'b0, rdy_before});
      out_ready = ~out_ready;
      #1;
      checkOutput("rnd_occ", {126'b0, occupancy}, 128'(sb.size()));
      checkOutput("rnd_valid", {127'b0, out_valid}, {127'b0, (sb.size() != 0)});
      if (!out_valid) begin
        checkOutput("rnd_ctrl_bubble", {120'b0, out_ctrl}, 128'b0);
        checkOutput("rnd_addr_bubble", {123'b0, out_addr}, 128'b0);
      end
      fire_in  = in_valid & in_ready;
      fire_out = out_valid & out_ready;
      if (fire_out && sb.size() != 0) begin
        head = sb.pop_front();
        checkOutput("rnd_data", out_data, head.data);
        checkOutput("rnd_ctrl", {120'b0, out_ctrl}, {120'b0, head.ctrl});
        checkOutput("rnd_addr", {123'b0, out_addr}, {123'b0, head.addr});
      end
      if (fire_in) sb.push_back(offer);
      pending = in_valid & ~fire_in;
      tick();
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pr_elastic_stage.md
Name: pr_elastic_stage

Overview:
- Parametrised, flow-controlled pipeline register for CPU stage boundaries (IF/ID … MEM/WB) and NoC-side pipelining.
- Unlike a plain per-clock register, it carries a valid/ready handshake with a 2-entry skid buffer, so IN_READY is driven from a flop.
- Adds a synchronous FLUSH and bubble masking: control fields (write enables, read strobes) are forced to zero whenever the output is not valid.

Parameters:
- DATA_WIDTH, 128, payload bits (PC, ALU out, read data, FPU out, …); passed through unmasked.
- CTRL_WIDTH, 8, control bits (reg/freg write enables, mem read, value select, …); zeroed on bubble, flush and reset.
- ADDR_WIDTH, 5, destination register address field; zeroed on bubble.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- FLUSH  input  1  synchronous kill of all held entries.
- IN_VALID  input  1  upstream entry present.
- IN_READY  output  1  stage can accept; registered.
- IN_DATA  input  DATA_WIDTH  upstream payload.
- IN_CTRL  input  CTRL_WIDTH  upstream control.
- IN_ADDR  input  ADDR_WIDTH  upstream destination register address.
- OUT_VALID  output  1  entry present at output.
- OUT_READY  input  1  downstream accepts.
- OUT_DATA  output  DATA_WIDTH  payload of head entry.
- OUT_CTRL  output  CTRL_WIDTH  control of head entry; 0 when OUT_VALID=0.
- OUT_ADDR  output  ADDR_WIDTH  address of head entry; 0 when OUT_VALID=0.
- OCCUPANCY  output  2  held entries, 0..2.

Behaviour:
- Storage:
  - Main register M (drives outputs) and skid register S, each with a valid flag.
  - Transfers: in_fire = IN_VALID & IN_READY; out_fire = OUT_VALID & OUT_READY.
- Reset (async, RESET=1):
  - M, S valid flags, data, ctrl and addr are cleared to 0.
  - IN_READY=1, OUT_VALID=0, OUTs=0, OCCUPANCY=0.
  - Deassertion takes effect at the next CLK edge.
- Latency: 1 cycle. An entry accepted at edge N appears at OUT at edge N if M is empty or draining; otherwise it waits in S.
- Handshake outputs:
  - IN_READY = ~S.valid (flop output; no combinational path from OUT_READY).
  - OUT_VALID = M.valid.
- Per-edge update, FLUSH=0:
  - M empty or out_fire, S valid: M<=S, S cleared; the input is also accepted if in_fire and lands in S or M per order.
  - M empty or out_fire, S empty: M<=input if in_fire, else M.valid<=0.
  - M valid, no out_fire, in_fire: S<=input.
  - FIFO order is always preserved; an entry never bypasses S.
- FLUSH=1 at an edge:
  - M.valid<=0 and S.valid<=0.
  - Any in_fire that cycle is discarded.
  - out_fire that cycle still counts as consumed downstream.
  - Data fields may hold stale values; ctrl/addr read as 0 via masking.
- Masking: OUT_CTRL and OUT_ADDR are AND-ed with OUT_VALID. OUT_DATA is not masked.
- OCCUPANCY = M.valid + S.valid.
- Boundaries:
  - Full (OCCUPANCY=2): IN_READY=0; upstream must hold its data.
  - Empty: OUT_VALID=0.
  - Simultaneous in_fire and out_fire with OCCUPANCY=1: stays at 1 (pure pass-through).
  - Simultaneous in_fire and out_fire with OCCUPANCY=2: impossible, since IN_READY=0.
  - Reset mid-transfer: the entry is lost and no spurious OUT_VALID follows.
- Legacy mode: with OUT_READY tied 1 and IN_VALID tied 1, the block is a plain 1-cycle register with a bubble on flush.

Test Plan:
- Reset then release, IN_VALID=0 -> OUT_VALID=0, OUT_CTRL=0, OUT_ADDR=0, IN_READY=1, OCCUPANCY=0.
- Stream 0x11,0x22,0x33 with OUT_READY=1 -> each appears on OUT one edge after acceptance, in order; OCCUPANCY stays 1; IN_READY stays 1.
- OUT_READY=0, present A=0xAA then B=0xBB -> OUT=A, OCCUPANCY=2, IN_READY=0; the offered C=0xCC is not accepted. Raise OUT_READY -> outputs A, B, C in order with no loss or duplication.
- Full (A, B held), IN_CTRL=0xFF, FLUSH=1 -> next cycle OUT_VALID=0, OUT_CTRL=0x00, OUT_ADDR=0, OCCUPANCY=0, IN_READY=1.
- RESET pulsed asynchronously between edges while OCCUPANCY=2 -> outputs go to zero immediately without a clock; no entry emerges after release.
- Random IN_VALID/OUT_READY for 10k cycles against a scoreboard -> sequence identical to the input; IN_READY never depends combinationally on OUT_READY; OUT_CTRL is 0 whenever OUT_VALID=0.
